// File: rtl/feb_tdo_capture.sv
// Shadows the FEB TAP from the TMS stream we drive and packs the selected FEB's Shift-DR TDO
// into a byte buffer, which VME reads back one byte per strobe with a DTACK handshake.
module feb_tdo_capture #(
  parameter int TMR   = 0,
  parameter int ADR_W = 9
) (
  input  logic           FASTCLK,
  input  logic           clr_jtagsetup,
  input  logic           TCK_RISE_EN,
  input  logic           JTAGENA,
  input  logic           TMS,
  input  logic [4:0]     TDO,
  input  logic [2:0]     FEB_SEL,
  input  logic           RD_STROBE,
  input  logic           RD_PTR_RST,
  output logic [7:0]     RD_DATA,
  output wire            DTACK_B,
  output logic [ADR_W:0] BYTE_CNT,
  output logic [3:0]     TAP_STATE,
  output logic           OVERFLOW,
  output logic           PARTIAL
);

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI      = 4'hC, SEL_DR   = 4'h7, CAP_DR   = 4'h6,
    SHIFT_DR = 4'h2, EXIT1_DR = 4'h1, PAUSE_DR = 4'h3, EXIT2_DR = 4'h0,
    UPD_DR   = 4'h5, SEL_IR   = 4'h4, CAP_IR   = 4'hE, SHIFT_IR = 4'hA,
    EXIT1_IR = 4'h9, PAUSE_IR = 4'hB, EXIT2_IR = 4'h8, UPD_IR   = 4'hD
  } tap_t;

  localparam logic [ADR_W:0] C_DEPTH = {1'b1, {ADR_W{1'b0}}};

  tap_t             r_tap;
  logic [7:0]       r_sr;
  logic             r_wr_pend;
  logic [7:0]       r_wr_dat;
  logic [ADR_W-1:0] r_wptr;
  logic [ADR_W:0]   r_byte_cnt;
  logic             r_ovf;
  logic             r_partial;
  logic [7:0]       r_mem [0:(1<<ADR_W)-1];
  logic             r_rd_s1, r_rd_s2, r_rd_s3;
  logic             r_ack1, r_dtack;
  logic [ADR_W-1:0] r_rptr;
  logic [7:0]       r_rd_data;

  logic       w_adv, w_sel_ok, w_cap, w_bit, w_leave, w_byte_done, w_partial_set, w_full;
  logic       w_rd_lead, w_rd_trail;
  logic [7:0] w_tdo_ext;
  logic [2:0] w_cnt, w_cnt_post, w_cnt_nxt;

  assign w_adv       = TCK_RISE_EN & JTAGENA;
  assign w_sel_ok    = (FEB_SEL >= 3'd1) && (FEB_SEL <= 3'd5);
  assign w_tdo_ext   = {3'b000, TDO};
  assign w_bit       = w_tdo_ext[FEB_SEL - 3'd1];
  assign w_cap       = w_adv && (r_tap == SHIFT_DR) && w_sel_ok;
  assign w_leave     = w_adv && TMS && ((r_tap == SHIFT_DR) || (r_tap == CAP_DR));
  assign w_cnt_post  = w_cap ? (w_cnt + 3'd1) : w_cnt;
  assign w_cnt_nxt   = w_leave ? 3'd0 : w_cnt_post;
  assign w_byte_done = w_cap && (w_cnt == 3'd7);
  assign w_partial_set = w_leave && (w_cnt_post != 3'd0);
  assign w_full      = (r_byte_cnt == C_DEPTH);

  // Bit counter is the only state that a single upset could desynchronise from the chain.
  generate
    if (TMR != 0) begin : g_cnt_tmr
      logic [2:0] r_cnt_a, r_cnt_b, r_cnt_c;
      always_ff @(posedge FASTCLK or posedge clr_jtagsetup) begin
        if (clr_jtagsetup) begin
          r_cnt_a <= 3'd0;
          r_cnt_b <= 3'd0;
          r_cnt_c <= 3'd0;
        end else begin
          r_cnt_a <= w_cnt_nxt;
          r_cnt_b <= w_cnt_nxt;
          r_cnt_c <= w_cnt_nxt;
        end
      end
      assign w_cnt = (r_cnt_a & r_cnt_b) | (r_cnt_a & r_cnt_c) | (r_cnt_b & r_cnt_c);
    end else begin : g_cnt_single
      logic [2:0] r_cnt;
      always_ff @(posedge FASTCLK or posedge clr_jtagsetup) begin
        if (clr_jtagsetup) r_cnt <= 3'd0;
        else               r_cnt <= w_cnt_nxt;
      end
      assign w_cnt = r_cnt;
    end
  endgenerate

  always_ff @(posedge FASTCLK or posedge clr_jtagsetup) begin
    if (clr_jtagsetup) begin
      r_tap <= TLR;
    end else if (w_adv) begin
      case (r_tap)
        TLR:      r_tap <= TMS ? TLR      : RTI;
        RTI:      r_tap <= TMS ? SEL_DR   : RTI;
        SEL_DR:   r_tap <= TMS ? SEL_IR   : CAP_DR;
        CAP_DR:   r_tap <= TMS ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: r_tap <= TMS ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: r_tap <= TMS ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: r_tap <= TMS ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: r_tap <= TMS ? UPD_DR   : SHIFT_DR;
        UPD_DR:   r_tap <= TMS ? SEL_DR   : RTI;
        SEL_IR:   r_tap <= TMS ? TLR      : CAP_IR;
        CAP_IR:   r_tap <= TMS ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: r_tap <= TMS ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: r_tap <= TMS ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: r_tap <= TMS ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: r_tap <= TMS ? UPD_IR   : SHIFT_IR;
        UPD_IR:   r_tap <= TMS ? SEL_DR   : RTI;
        default:  r_tap <= TLR;
      endcase
    end
  end

  always_ff @(posedge FASTCLK or posedge clr_jtagsetup) begin
    if (clr_jtagsetup) begin
      r_sr       <= 8'd0;
      r_wr_pend  <= 1'b0;
      r_wr_dat   <= 8'd0;
      r_wptr     <= '0;
      r_byte_cnt <= '0;
      r_ovf      <= 1'b0;
      r_partial  <= 1'b0;
    end else begin
      r_wr_pend <= w_byte_done;
      if (w_cap)         r_sr     <= {w_bit, r_sr[7:1]};
      if (w_byte_done)   r_wr_dat <= {w_bit, r_sr[7:1]};
      if (w_partial_set) r_partial <= 1'b1;
      if (r_wr_pend) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_byte_cnt <= r_byte_cnt + (ADR_W+1)'(1);
          // Saturate so the last slot is never revisited once full.
          if (r_wptr != {ADR_W{1'b1}}) r_wptr <= r_wptr + ADR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge FASTCLK) begin
    if (r_wr_pend && !w_full) r_mem[r_wptr] <= r_wr_dat;
  end

  assign w_rd_lead  = r_rd_s2 & ~r_rd_s3;
  assign w_rd_trail = ~r_rd_s2 & r_rd_s3;

  always_ff @(posedge FASTCLK or posedge clr_jtagsetup) begin
    if (clr_jtagsetup) begin
      r_rd_s1   <= 1'b0;
      r_rd_s2   <= 1'b0;
      r_rd_s3   <= 1'b0;
      r_ack1    <= 1'b0;
      r_dtack   <= 1'b0;
      r_rptr    <= '0;
      r_rd_data <= 8'd0;
    end else begin
      r_rd_s1 <= RD_STROBE;
      r_rd_s2 <= r_rd_s1;
      r_rd_s3 <= r_rd_s2;
      r_ack1  <= w_rd_lead;
      if (w_rd_lead) r_rd_data <= r_mem[r_rptr];
      if (!r_rd_s2)    r_dtack <= 1'b0;
      else if (r_ack1) r_dtack <= 1'b1;
      if (RD_PTR_RST)      r_rptr <= '0;
      else if (w_rd_trail) r_rptr <= r_rptr + ADR_W'(1);
    end
  end

  assign DTACK_B   = r_dtack ? 1'b0 : 1'bz;
  assign RD_DATA   = r_rd_data;
  assign BYTE_CNT  = r_byte_cnt;
  assign TAP_STATE = r_tap;
  assign OVERFLOW  = r_ovf;
  assign PARTIAL   = r_partial;

endmodule

// File: tb/tb_feb_tdo_capture.sv
// Bench for feb_tdo_capture: random TDO/TMS traffic against a queue-based model of the
// JTAG shift path, buffer and VME readback, plus literal expectations from hand-worked cases.
`timescale 1ns/1ps
module tb_feb_tdo_capture;
  logic       FASTCLK = 1'b0;
  logic       clr = 1'b0, tck_en = 1'b0, jtagena = 1'b1, tms = 1'b0;
  logic       rd_strobe = 1'b0, rd_ptr_rst = 1'b0;
  logic [4:0] tdo = 5'd0;
  logic [2:0] feb_sel = 3'd0;
  logic [7:0] rd_data;
  wire        dtack_b;
  logic [9:0] byte_cnt;
  logic [3:0] tap_state;
  logic       ovf, partial;

  pullup (dtack_b);
  always #5 FASTCLK = ~FASTCLK;

  feb_tdo_capture #(.TMR(0), .ADR_W(9)) dut (
    .FASTCLK(FASTCLK), .clr_jtagsetup(clr), .TCK_RISE_EN(tck_en), .JTAGENA(jtagena),
    .TMS(tms), .TDO(tdo), .FEB_SEL(feb_sel), .RD_STROBE(rd_strobe), .RD_PTR_RST(rd_ptr_rst),
    .RD_DATA(rd_data), .DTACK_B(dtack_b), .BYTE_CNT(byte_cnt), .TAP_STATE(tap_state),
    .OVERFLOW(ovf), .PARTIAL(partial)
  );

  int n_chk = 0, n_pass = 0;
  bit busy = 1'b1;

  // Reference model
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];
  logic [3:0] m_tap = 4'hF;
  bit         m_bits [$];
  int         m_cnt = 0, m_rptr = 0;
  bit         m_ovf = 0, m_partial = 0;
  logic [7:0] m_mem [512];
  bit         m_known [512];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic init_tab();
    nxt0[4'hF]=4'hC; nxt1[4'hF]=4'hF;  nxt0[4'hC]=4'hC; nxt1[4'hC]=4'h7;
    nxt0[4'h7]=4'h6; nxt1[4'h7]=4'h4;  nxt0[4'h6]=4'h2; nxt1[4'h6]=4'h1;
    nxt0[4'h2]=4'h2; nxt1[4'h2]=4'h1;  nxt0[4'h1]=4'h3; nxt1[4'h1]=4'h5;
    nxt0[4'h3]=4'h3; nxt1[4'h3]=4'h0;  nxt0[4'h0]=4'h2; nxt1[4'h0]=4'h5;
    nxt0[4'h5]=4'hC; nxt1[4'h5]=4'h7;  nxt0[4'h4]=4'hE; nxt1[4'h4]=4'hF;
    nxt0[4'hE]=4'hA; nxt1[4'hE]=4'h9;  nxt0[4'hA]=4'hA; nxt1[4'hA]=4'h9;
    nxt0[4'h9]=4'hB; nxt1[4'h9]=4'hD;  nxt0[4'hB]=4'hB; nxt1[4'hB]=4'h8;
    nxt0[4'h8]=4'hA; nxt1[4'h8]=4'hD;  nxt0[4'hD]=4'hC; nxt1[4'hD]=4'h7;
  endtask

  task automatic model_edge(input bit t, input logic [4:0] tv, input logic [2:0] sel, input bit ena);
    logic [3:0] nt;
    int val;
    if (!ena) return;
    if (m_tap == 4'h2 && sel >= 1 && sel <= 5) begin
      m_bits.push_back(tv[sel-1]);
      if (m_bits.size() == 8) begin
        val = 0;
        for (int i = 0; i < 8; i++) val += int'(m_bits[i]) << i;
        if (m_cnt < 512) begin
          m_mem[m_cnt] = val[7:0];
          m_known[m_cnt] = 1'b1;
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
        m_bits.delete();
      end
    end
    nt = t ? nxt1[m_tap] : nxt0[m_tap];
    if (nt == 4'h1 && m_bits.size() != 0) begin
      m_partial = 1'b1;
      m_bits.delete();
    end
    m_tap = nt;
  endtask

  task automatic tck(input bit t, input bit b);
    @(negedge FASTCLK);
    busy = 1'b1;
    tms = t;
    tdo = 5'($urandom);
    if (feb_sel >= 1 && feb_sel <= 5) tdo[feb_sel-1] = b;
    tck_en = 1'b1;
    @(negedge FASTCLK);
    tck_en = 1'b0;
    model_edge(t, tdo, feb_sel, jtagena);
    @(negedge FASTCLK);
    busy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge FASTCLK);
    busy = 1'b1;
    clr = 1'b1;
    @(negedge FASTCLK);
    @(negedge FASTCLK);
    clr = 1'b0;
    m_tap = 4'hF; m_bits.delete(); m_cnt = 0; m_ovf = 0; m_partial = 0; m_rptr = 0;
    @(negedge FASTCLK);
    busy = 1'b0;
  endtask

  task automatic go_shift();
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    tck(1'b0, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
  endtask

  task automatic reenter_shift();
    tck(1'b0, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0);
  endtask

  task automatic shift_byte(input logic [7:0] v, input bit exit_last);
    for (int i = 0; i < 8; i++) tck(exit_last && (i == 7), v[i]);
  endtask

  task automatic vme_read(input string nm);
    bit seen = 1'b0, rel = 1'b0;
    @(negedge FASTCLK);
    rd_strobe = 1'b1;
    @(negedge FASTCLK);
    chk({nm, "_dtack_early"}, int'(dtack_b === 1'b0), 0);
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge FASTCLK);
      if (dtack_b === 1'b0) seen = 1'b1;
    end
    chk({nm, "_dtack_low"}, int'(seen), 1);
    if (seen && m_known[m_rptr]) chk({nm, "_data"}, int'(rd_data), int'(m_mem[m_rptr]));
    rd_strobe = 1'b0;
    for (int n = 0; n < 10 && !rel; n++) begin
      @(negedge FASTCLK);
      if (dtack_b !== 1'b0) rel = 1'b1;
    end
    chk({nm, "_dtack_release"}, int'(rel), 1);
    repeat (3) @(negedge FASTCLK);
    m_rptr = (m_rptr + 1) % 512;
  endtask

  task automatic ptr_reset();
    @(negedge FASTCLK);
    rd_ptr_rst = 1'b1;
    @(negedge FASTCLK);
    rd_ptr_rst = 1'b0;
    m_rptr = 0;
  endtask

  initial begin
    forever begin
      @(posedge FASTCLK);
      #2;
      if (!busy) begin
        chk("cyc_tap", int'(tap_state), int'(m_tap));
        chk("cyc_byte_cnt", int'(byte_cnt), m_cnt);
        chk("cyc_overflow", int'(ovf), int'(m_ovf));
        chk("cyc_partial", int'(partial), int'(m_partial));
      end
    end
  end

  initial begin
    logic [7:0] first_byte;
    init_tab();
    first_byte = 8'b0100_1101;
    do_reset();
    chk("rst_tap", int'(tap_state), 15);
    chk("rst_byte_cnt", int'(byte_cnt), 0);
    chk("rst_flags", int'({ovf, partial}), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_dtack_z", int'(dtack_b !== 1'b0), 1);

    go_shift();
    chk("nav_shift_dr", int'(tap_state), 2);

    // bits 1,0,1,1,0,0,1,0 in time order, last on the exit edge
    feb_sel = 3'd3;
    shift_byte(first_byte, 1'b1);
    chk("byte0_cnt", int'(byte_cnt), 1);
    chk("byte0_partial", int'(partial), 0);
    chk("byte0_exit1", int'(tap_state), 1);
    chk("model_byte0", int'(m_mem[0]), 8'h4D);

    reenter_shift();
    feb_sel = 3'(1 + $urandom_range(0, 4));
    shift_byte(8'($urandom), 1'b0);
    feb_sel = 3'(1 + $urandom_range(0, 4));
    shift_byte(8'($urandom), 1'b1);
    chk("three_bytes", int'(byte_cnt), 3);

    vme_read("rd0");
    chk("rd0_literal", int'(rd_data), 8'h4D);
    vme_read("rd1");
    vme_read("rd2");
    ptr_reset();
    vme_read("rd_after_ptr_rst");
    chk("ptr_rst_literal", int'(rd_data), 8'h4D);

    reenter_shift();
    for (int i = 0; i < 4; i++) tck(1'b0, 1'($urandom));
    tck(1'b1, 1'($urandom));
    chk("partial_set", int'(partial), 1);
    chk("partial_cnt", int'(byte_cnt), 3);

    reenter_shift();
    feb_sel = 3'd0;
    for (int i = 0; i < 3; i++) tck(1'b0, 1'($urandom));
    feb_sel = 3'd2;
    for (int i = 0; i < 5; i++) tck(1'b0, 1'($urandom));
    chk("invalid_sel_no_count", int'(byte_cnt), 3);
    for (int i = 0; i < 3; i++) tck(i == 2, 1'($urandom));
    chk("invalid_sel_byte_done", int'(byte_cnt), 4);
    chk("partial_sticky", int'(partial), 1);

    // Random TAP walk with random selects and ownership
    for (int i = 0; i < 400; i++) begin
      feb_sel = 3'($urandom_range(0, 7));
      jtagena = ($urandom_range(0, 7) != 0);
      tck($urandom_range(0, 3) == 0, 1'($urandom));
    end
    jtagena = 1'b1;

    go_shift();
    feb_sel = 3'd5;
    for (int i = 0; i < 4; i++) tck(1'b0, 1'($urandom));
    do_reset();
    chk("midrst_tap", int'(tap_state), 15);
    chk("midrst_byte_cnt", int'(byte_cnt), 0);
    chk("midrst_partial", int'(partial), 0);
    vme_read("midrst_rd0");
    chk("midrst_retained", int'(rd_data), 8'h4D);

    go_shift();
    for (int k = 0; k < 513; k++) begin
      feb_sel = 3'(1 + $urandom_range(0, 4));
      shift_byte(8'($urandom), k == 512);
    end
    chk("ovf_byte_cnt", int'(byte_cnt), 512);
    chk("ovf_flag", int'(ovf), 1);

    ptr_reset();
    for (int k = 0; k < 512; k++) vme_read("ovf_rd");
    vme_read("wrap_rd0");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
